// File: rtl/lc_transition_sequencer_pkg.sv
// lc_ctrl_pkg: shared life-cycle widths, decoded state encodings and sequencer enums
package lc_ctrl_pkg;
  function automatic int vbits(int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction
  localparam int NumLcStates = 21;
  localparam int DecLcStateWidth = vbits(NumLcStates);
  localparam int DecLcStateNumRep = 32 / DecLcStateWidth;
  localparam int ExtDecLcStateWidth = DecLcStateWidth * DecLcStateNumRep;
  typedef enum logic [DecLcStateWidth-1:0] {
    DecLcStRaw, DecLcStTestUnlocked0, DecLcStTestLocked0, DecLcStTestUnlocked1,
    DecLcStTestLocked1, DecLcStTestUnlocked2, DecLcStTestLocked2, DecLcStTestUnlocked3,
    DecLcStTestLocked3, DecLcStTestUnlocked4, DecLcStTestLocked4, DecLcStTestUnlocked5,
    DecLcStTestLocked5, DecLcStTestUnlocked6, DecLcStTestLocked6, DecLcStTestUnlocked7,
    DecLcStDev, DecLcStProd, DecLcStProdEnd, DecLcStRma, DecLcStScrap,
    DecLcStPostTrans, DecLcStEscalate, DecLcStInvalid
  } dec_lc_state_e;
  typedef logic [ExtDecLcStateWidth-1:0] ext_dec_lc_state_t;
  typedef enum logic [1:0] {ErrNone, ErrIllegal, ErrTimeout, ErrProg} lc_err_e;
  typedef enum logic [2:0] {StIdle, StCheck, StProg, StDone, StErr, StEsc} lc_seq_state_e;
endpackage

// File: rtl/lc_transition_sequencer_if.sv
// lc_transition_sequencer_if: request, programming and status signals of the transition sequencer
interface lc_transition_sequencer_if;
  import lc_ctrl_pkg::*;
  logic cur_state_valid_i;
  logic [DecLcStateWidth-1:0] cur_dec_state_i;
  logic escalate_i;
  logic trans_req_i;
  logic [DecLcStateWidth-1:0] trans_target_i;
  logic prog_req_o;
  logic [ExtDecLcStateWidth-1:0] prog_target_o;
  logic prog_ack_i;
  logic prog_err_i;
  logic trans_done_o;
  logic trans_err_o;
  logic [1:0] err_code_o;
  logic [DecLcStateWidth-1:0] dec_state_o;
  modport slave (
    input cur_state_valid_i, cur_dec_state_i, escalate_i, trans_req_i, trans_target_i,
    input prog_ack_i, prog_err_i,
    output prog_req_o, prog_target_o, trans_done_o, trans_err_o, err_code_o, dec_state_o
  );
  modport master (
    output cur_state_valid_i, cur_dec_state_i, escalate_i, trans_req_i, trans_target_i,
    output prog_ack_i, prog_err_i,
    input prog_req_o, prog_target_o, trans_done_o, trans_err_o, err_code_o, dec_state_o
  );
endinterface

// File: rtl/lc_dec_state_rep.sv
// lc_dec_state_rep: replicates one decoded state into every slot of the redundant form
module lc_dec_state_rep #(
  parameter int Width = 5,
  parameter int NumRep = 6
) (
  input  logic [Width-1:0]        state_i,
  output logic [Width*NumRep-1:0] state_o
);
  for (genvar k = 0; k < NumRep; k++) begin : g_rep
    assign state_o[k*Width +: Width] = state_i;
  end
endmodule

// File: rtl/lc_transition_sequencer.sv
// lc_transition_sequencer: checks and programs one life-cycle transition per power cycle
module lc_transition_sequencer
  import lc_ctrl_pkg::*;
#(
  parameter int TimeoutCycles = 16
) (
  input logic clk_i,
  input logic rst_i,
  lc_transition_sequencer_if.slave bus
);
  localparam int TimerW = vbits(TimeoutCycles);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TimeoutCycles - 1);
  localparam logic [DecLcStateWidth-1:0] MaxReal = DecLcStateWidth'(NumLcStates - 1);
  lc_seq_state_e state_q;
  logic [TimerW-1:0] timer_q;
  logic [DecLcStateWidth-1:0] target_q, cur_q;
  dec_lc_state_e dec_state_q;
  logic prog_req_q, done_q, err_q;
  lc_err_e err_code_q;
  ext_dec_lc_state_t prog_target_q, target_rep;
  logic cur_ok, legal;
  lc_dec_state_rep #(.Width(DecLcStateWidth), .NumRep(DecLcStateNumRep)) u_rep (
    .state_i(target_q),
    .state_o(target_rep)
  );
  assign cur_ok = bus.cur_state_valid_i && (bus.cur_dec_state_i <= MaxReal);
  assign legal = (cur_q <= MaxReal) && (target_q <= MaxReal) && (target_q > cur_q);
  assign bus.prog_req_o = prog_req_q;
  assign bus.prog_target_o = prog_target_q;
  assign bus.trans_done_o = done_q;
  assign bus.trans_err_o = err_q;
  assign bus.err_code_o = err_code_q;
  assign bus.dec_state_o = dec_state_q;
  // Sequencer FSM with registered outputs; escalation overrides every state, terminal states hold
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      timer_q <= '0;
      target_q <= '0;
      cur_q <= '0;
      dec_state_q <= DecLcStInvalid;
      prog_req_q <= 1'b0;
      prog_target_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      err_code_q <= ErrNone;
    end else if (bus.escalate_i) begin
      state_q <= StEsc;
      prog_req_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      dec_state_q <= DecLcStEscalate;
    end else begin
      case (state_q)
        StIdle: begin
          dec_state_q <= cur_ok ? dec_lc_state_e'(bus.cur_dec_state_i) : DecLcStInvalid;
          if (bus.trans_req_i && bus.cur_state_valid_i) begin
            target_q <= bus.trans_target_i;
            cur_q <= bus.cur_dec_state_i;
            state_q <= StCheck;
          end
        end
        StCheck: begin
          state_q <= legal ? StProg : StErr;
          timer_q <= '0;
          prog_req_q <= legal;
          prog_target_q <= legal ? target_rep : prog_target_q;
          err_q <= !legal;
          err_code_q <= legal ? ErrNone : ErrIllegal;
          dec_state_q <= legal ? dec_state_q : DecLcStPostTrans;
        end
        StProg: begin
          if (bus.prog_ack_i || timer_q == TimerLast) begin
            prog_req_q <= 1'b0;
            dec_state_q <= DecLcStPostTrans;
            done_q <= bus.prog_ack_i && !bus.prog_err_i;
            err_q <= !(bus.prog_ack_i && !bus.prog_err_i);
            err_code_q <= !bus.prog_ack_i ? ErrTimeout : (bus.prog_err_i ? ErrProg : ErrNone);
            state_q <= (bus.prog_ack_i && !bus.prog_err_i) ? StDone : StErr;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lc_transition_sequencer.sv
// tb_lc_transition_sequencer: table, random and hand-written checks of the transition sequencer
module tb_lc_transition_sequencer;
  import lc_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  lc_transition_sequencer_if ifc();
  lc_transition_sequencer dut (.clk_i(clk), .rst_i(rst), .bus(ifc.slave));

  typedef struct {
    int cur;
    int tgt;
    int ack_d;
    bit aerr;
    int e_req;
    int e_done;
    int e_err;
    int e_code;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic void model(input int cur, input int tgt, input int d, input bit aerr,
                                output int req, output int dn, output int er, output int code);
    if (!(cur <= 20 && tgt <= 20 && tgt > cur)) begin
      req = 0; dn = 0; er = 1; code = 1;
    end else if (d >= 0 && d < 16) begin
      req = d + 1; dn = aerr ? 0 : 1; er = aerr ? 1 : 0; code = aerr ? 3 : 0;
    end else begin
      req = 16; dn = 0; er = 1; code = 2;
    end
  endfunction

  task automatic run_txn(input int cur, input int tgt, input int d, input bit aerr,
                         output int fin, output int req, output int bad, output int req_end);
    logic [29:0] exp_rep;
    logic [4:0] t5;
    t5 = tgt[4:0];
    for (int k = 0; k < 6; k++) exp_rep[k*5 +: 5] = t5;
    rst = 1'b1;
    ifc.escalate_i = 1'b0;
    ifc.prog_ack_i = 1'b0;
    ifc.prog_err_i = aerr;
    ifc.trans_req_i = 1'b0;
    ifc.cur_state_valid_i = 1'b1;
    ifc.cur_dec_state_i = cur[4:0];
    ifc.trans_target_i = t5;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ifc.trans_req_i = 1'b1;
    @(negedge clk);
    ifc.trans_req_i = 1'b0;
    fin = 0; req = 0; bad = 0;
    for (int c = 0; c < 60 && fin == 0; c++) begin
      if (ifc.trans_done_o || ifc.trans_err_o) fin = 1;
      else begin
        if (ifc.prog_req_o) begin
          if (ifc.prog_target_o != exp_rep) bad++;
          ifc.prog_ack_i = (req == d);
          req++;
        end else ifc.prog_ack_i = 1'b0;
        @(negedge clk);
      end
    end
    ifc.prog_ack_i = 1'b0;
    req_end = int'(ifc.prog_req_o);
  endtask

  task automatic score(input string tag, input int fin, input int req, input int bad, input int req_end,
                       input int e_req, input int e_done, input int e_err, input int e_code);
    check({tag, " finished"}, fin, 1);
    check({tag, " req_cycles"}, req, e_req);
    check({tag, " target_bad"}, bad, 0);
    check({tag, " req_end"}, req_end, 0);
    check({tag, " done"}, int'(ifc.trans_done_o), e_done);
    check({tag, " err"}, int'(ifc.trans_err_o), e_err);
    check({tag, " code"}, int'(ifc.err_code_o), e_code);
    check({tag, " dec_state"}, int'(ifc.dec_state_o), 21);
  endtask

  initial begin
    vec_t vecs[9];
    int fin, req, bad, req_end, w;
    int e_req, e_done, e_err, e_code;
    int cur, tgt, d;
    bit aerr;
    vecs[0] = '{cur: 1,  tgt: 2,  ack_d: 3,  aerr: 0, e_req: 4,  e_done: 1, e_err: 0, e_code: 0};
    vecs[1] = '{cur: 10, tgt: 4,  ack_d: 0,  aerr: 0, e_req: 0,  e_done: 0, e_err: 1, e_code: 1};
    vecs[2] = '{cur: 21, tgt: 20, ack_d: 0,  aerr: 0, e_req: 0,  e_done: 0, e_err: 1, e_code: 1};
    vecs[3] = '{cur: 0,  tgt: 20, ack_d: -1, aerr: 0, e_req: 16, e_done: 0, e_err: 1, e_code: 2};
    vecs[4] = '{cur: 0,  tgt: 20, ack_d: 15, aerr: 0, e_req: 16, e_done: 1, e_err: 0, e_code: 0};
    vecs[5] = '{cur: 3,  tgt: 5,  ack_d: 0,  aerr: 1, e_req: 1,  e_done: 0, e_err: 1, e_code: 3};
    vecs[6] = '{cur: 19, tgt: 20, ack_d: 16, aerr: 0, e_req: 16, e_done: 0, e_err: 1, e_code: 2};
    vecs[7] = '{cur: 5,  tgt: 5,  ack_d: 0,  aerr: 0, e_req: 0,  e_done: 0, e_err: 1, e_code: 1};
    vecs[8] = '{cur: 2,  tgt: 21, ack_d: 0,  aerr: 0, e_req: 0,  e_done: 0, e_err: 1, e_code: 1};
    ifc.cur_state_valid_i = 1'b1;
    ifc.cur_dec_state_i = 5'd0;
    ifc.escalate_i = 1'b0;
    ifc.trans_req_i = 1'b0;
    ifc.trans_target_i = 5'd0;
    ifc.prog_ack_i = 1'b0;
    ifc.prog_err_i = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst dec_state", int'(ifc.dec_state_o), 23);
    check("rst prog_req", int'(ifc.prog_req_o), 0);
    check("rst prog_target", int'(ifc.prog_target_o), 0);
    check("rst done", int'(ifc.trans_done_o), 0);
    check("rst err", int'(ifc.trans_err_o), 0);
    check("rst code", int'(ifc.err_code_o), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle dec_state cur0", int'(ifc.dec_state_o), 0);
    ifc.cur_state_valid_i = 1'b0;
    ifc.trans_req_i = 1'b1;
    ifc.trans_target_i = 5'd3;
    @(negedge clk);
    ifc.trans_req_i = 1'b0;
    repeat (3) @(negedge clk);
    check("invalid dec_state", int'(ifc.dec_state_o), 23);
    check("invalid req ignored", int'(ifc.prog_req_o), 0);
    check("invalid no err", int'(ifc.trans_err_o), 0);
    ifc.cur_state_valid_i = 1'b1;
    ifc.cur_dec_state_i = 5'd21;
    @(negedge clk);
    check("cur21 dec_state", int'(ifc.dec_state_o), 23);

    for (int i = 0; i < 9; i++) begin
      run_txn(vecs[i].cur, vecs[i].tgt, vecs[i].ack_d, vecs[i].aerr, fin, req, bad, req_end);
      score($sformatf("vec%0d", i), fin, req, bad, req_end,
            vecs[i].e_req, vecs[i].e_done, vecs[i].e_err, vecs[i].e_code);
    end

    for (int i = 0; i < 25; i++) begin
      cur = $urandom_range(0, 23);
      tgt = $urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : cur + $urandom_range(1, 4);
      d = $urandom_range(0, 19) - 2;
      aerr = 1'($urandom_range(0, 1));
      model(cur, tgt, d, aerr, e_req, e_done, e_err, e_code);
      run_txn(cur, tgt, d, aerr, fin, req, bad, req_end);
      score($sformatf("rnd%0d cur%0d tgt%0d d%0d e%0d", i, cur, tgt, d, aerr), fin, req, bad, req_end,
            e_req, e_done, e_err, e_code);
    end

    rst = 1'b1;
    ifc.cur_state_valid_i = 1'b1;
    ifc.cur_dec_state_i = 5'd1;
    ifc.trans_target_i = 5'd2;
    ifc.prog_err_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ifc.trans_req_i = 1'b1;
    @(negedge clk);
    ifc.trans_req_i = 1'b0;
    w = 0;
    while (!ifc.prog_req_o && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("esc prog_req seen", int'(ifc.prog_req_o), 1);
    @(negedge clk);
    ifc.prog_ack_i = 1'b1;
    ifc.escalate_i = 1'b1;
    @(negedge clk);
    ifc.prog_ack_i = 1'b0;
    ifc.escalate_i = 1'b0;
    check("esc dec_state", int'(ifc.dec_state_o), 22);
    check("esc done", int'(ifc.trans_done_o), 0);
    check("esc err", int'(ifc.trans_err_o), 0);
    check("esc prog_req", int'(ifc.prog_req_o), 0);
    check("esc code", int'(ifc.err_code_o), 0);
    ifc.cur_dec_state_i = 5'd0;
    ifc.trans_target_i = 5'd5;
    ifc.trans_req_i = 1'b1;
    @(negedge clk);
    ifc.trans_req_i = 1'b0;
    repeat (4) @(negedge clk);
    check("esc sticky dec_state", int'(ifc.dec_state_o), 22);
    check("esc sticky prog_req", int'(ifc.prog_req_o), 0);
    check("esc sticky done", int'(ifc.trans_done_o), 0);
    rst = 1'b1;
    @(negedge clk);
    check("esc rst dec_state", int'(ifc.dec_state_o), 23);
    rst = 1'b0;
    @(negedge clk);
    check("esc rst idle dec_state", int'(ifc.dec_state_o), 0);

    ifc.cur_dec_state_i = 5'd4;
    ifc.trans_target_i = 5'd9;
    ifc.trans_req_i = 1'b1;
    @(negedge clk);
    ifc.trans_req_i = 1'b0;
    repeat (3) @(negedge clk);
    check("midprog prog_req", int'(ifc.prog_req_o), 1);
    rst = 1'b1;
    @(negedge clk);
    check("midprog rst drops req", int'(ifc.prog_req_o), 0);
    check("midprog rst target", int'(ifc.prog_target_o), 0);
    rst = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
